// File: rtl/rv32i_alu_pkg.sv
// rtl/rv32i_alu_pkg.sv - shared width constant and operation encoding for the RV32I ALU
package rv32i_alu_pkg;

    localparam int XLEN = 32;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'b0000,
        ALU_SUB   = 4'b0001,
        ALU_AND   = 4'b0010,
        ALU_OR    = 4'b0011,
        ALU_XOR   = 4'b0100,
        ALU_SLL   = 4'b0101,
        ALU_SRL   = 4'b0110,
        ALU_SRA   = 4'b0111,
        ALU_SLT   = 4'b1000,
        ALU_SLTU  = 4'b1001,
        ALU_PASSB = 4'b1010
    } alu_op_t;

endpackage

// File: rtl/rv32i_alu_shifter.sv
// rtl/rv32i_alu_shifter.sv - combinational barrel shifter for SLL, SRL and SRA
module rv32i_alu_shifter
    import rv32i_alu_pkg::*;
(
    input  logic [XLEN-1:0] a,
    input  logic [4:0]      shamt,
    input  logic            shift_left,
    input  logic            arithmetic,
    output logic [XLEN-1:0] y
);

    logic signed [XLEN:0] ext;
    logic signed [XLEN:0] shr;

    // One extra fill bit on top lets a single arithmetic shift cover both SRL and SRA.
    always_comb begin
        ext = {arithmetic & a[XLEN-1], a};
        shr = ext >>> shamt;
        if (shift_left) begin
            y = a << shamt;
        end else begin
            y = shr[XLEN-1:0];
        end
    end

endmodule

// File: rtl/rv32i_alu.sv
// rtl/rv32i_alu.sv - RV32I ALU: op mux, branch compare flags, one-cycle registered outputs
module rv32i_alu
    import rv32i_alu_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [3:0]      alu_control,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    output logic [XLEN-1:0] result,
    output logic            equal,
    output logic            less_than,
    output logic            less_than_unsigned
);

    alu_op_t         op;
    logic [XLEN-1:0] shift_y;
    logic            shift_left;
    logic            shift_arith;

    logic [XLEN-1:0] result_d, result_q;
    logic            equal_d, equal_q;
    logic            lt_d, lt_q;
    logic            ltu_d, ltu_q;

    assign op          = alu_op_t'(alu_control);
    assign shift_left  = (op == ALU_SLL);
    assign shift_arith = (op == ALU_SRA);

    rv32i_alu_shifter u_shifter (
        .a          (A),
        .shamt      (B[4:0]),
        .shift_left (shift_left),
        .arithmetic (shift_arith),
        .y          (shift_y)
    );

    // Flags are opcode-independent so branch resolution can use them with any ALU op.
    always_comb begin
        equal_d = (A == B);
        lt_d    = ($signed(A) < $signed(B));
        ltu_d   = (A < B);
    end

    always_comb begin
        result_d = '0;
        case (op)
            ALU_ADD:   result_d = A + B;
            ALU_SUB:   result_d = A - B;
            ALU_AND:   result_d = A & B;
            ALU_OR:    result_d = A | B;
            ALU_XOR:   result_d = A ^ B;
            ALU_SLL,
            ALU_SRL,
            ALU_SRA:   result_d = shift_y;
            ALU_SLT:   result_d = {{(XLEN-1){1'b0}}, lt_d};
            ALU_SLTU:  result_d = {{(XLEN-1){1'b0}}, ltu_d};
            ALU_PASSB: result_d = B;
            default:   result_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_q <= '0;
            equal_q  <= 1'b0;
            lt_q     <= 1'b0;
            ltu_q    <= 1'b0;
        end else begin
            result_q <= result_d;
            equal_q  <= equal_d;
            lt_q     <= lt_d;
            ltu_q    <= ltu_d;
        end
    end

    assign result             = result_q;
    assign equal              = equal_q;
    assign less_than          = lt_q;
    assign less_than_unsigned = ltu_q;

endmodule

// File: tb/tb_rv32i_alu.sv
// tb/tb_rv32i_alu.sv - self-checking bench for rv32i_alu with reference model and directed vectors
module tb_rv32i_alu;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  alu_control = 4'd0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic [31:0] result;
    logic        equal;
    logic        less_than;
    logic        less_than_unsigned;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    logic [31:0] exp_result;
    logic        exp_eq, exp_lt, exp_ltu;

    rv32i_alu dut (
        .clk                (clk),
        .reset              (reset),
        .alu_control        (alu_control),
        .A                  (A),
        .B                  (B),
        .result             (result),
        .equal              (equal),
        .less_than          (less_than),
        .less_than_unsigned (less_than_unsigned)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_result(input logic [3:0] op, input logic [31:0] a,
                                                 input logic [31:0] b);
        int unsigned sh;
        sh = b % 32;
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return a << sh;
            4'd6:    return a >> sh;
            4'd7:    return 32'($signed(a) >>> sh);
            4'd8:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9:    return (a < b) ? 32'd1 : 32'd0;
            4'd10:   return b;
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, want);
        end
    endtask

    // Model captures the expectation at each sampling edge; reset clears it asynchronously.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_result = 32'd0;
            exp_eq     = 1'b0;
            exp_lt     = 1'b0;
            exp_ltu    = 1'b0;
        end else begin
            exp_result = model_result(alu_control, A, B);
            exp_eq     = (A == B);
            exp_lt     = ($signed(A) < $signed(B));
            exp_ltu    = (A < B);
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_result", result, exp_result);
            chk("model_equal", 32'(equal), 32'(exp_eq));
            chk("model_lt", 32'(less_than), 32'(exp_lt));
            chk("model_ltu", 32'(less_than_unsigned), 32'(exp_ltu));
        end
    end

    task automatic step(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        alu_control = op;
        A = a;
        B = b;
        @(posedge clk);
        #1;
    endtask

    task automatic step_r(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] want);
        step(op, a, b);
        chk(name, result, want);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_result", result, 32'd0);
        chk("reset_flags", {29'd0, equal, less_than, less_than_unsigned}, 32'd0);

        @(negedge clk);
        reset = 1'b0;
        cmp_en = 1'b1;
        step_r("pre_reset_sub", 4'd1, 32'd9, 32'd2, 32'd7);

        // Asynchronous reset mid-cycle must clear the outputs without a clock edge.
        @(posedge clk);
        #3;
        alu_control = 4'd0;
        A = 32'd5;
        B = 32'd5;
        reset = 1'b1;
        #1;
        chk("async_reset_result", result, 32'd0);
        chk("async_reset_flags", {29'd0, equal, less_than, less_than_unsigned}, 32'd0);
        @(posedge clk);
        #1;
        chk("held_reset_result", result, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("post_reset_add", result, 32'd10);
        chk("post_reset_flags", {29'd0, equal, less_than, less_than_unsigned}, 32'h4);

        step_r("add_wrap", 4'd0, 32'hFFFFFFFF, 32'd1, 32'd0);
        step_r("sub_wrap", 4'd1, 32'd0, 32'd1, 32'hFFFFFFFF);

        step_r("and", 4'd2, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0);
        step_r("or", 4'd3, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0);
        step_r("xor", 4'd4, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00);
        step_r("passb", 4'd10, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h0FF00FF0);

        step_r("sll4", 4'd5, 32'h80000001, 32'h00000024, 32'h00000010);
        step_r("srl4", 4'd6, 32'h80000001, 32'h00000024, 32'h08000000);
        step_r("sra4", 4'd7, 32'h80000001, 32'h00000024, 32'hF8000000);
        step_r("sll32", 4'd5, 32'h80000001, 32'h00000020, 32'h80000001);
        step_r("sra31", 4'd7, 32'h80000000, 32'h0000001F, 32'hFFFFFFFF);
        step_r("srl31", 4'd6, 32'h80000000, 32'h0000001F, 32'h00000001);

        step_r("slt_cross", 4'd8, 32'h80000000, 32'h7FFFFFFF, 32'd1);
        chk("slt_cross_flags", {29'd0, equal, less_than, less_than_unsigned}, 32'h2);
        step_r("sltu_cross", 4'd9, 32'h80000000, 32'h7FFFFFFF, 32'd0);
        step_r("slt_swap", 4'd8, 32'h7FFFFFFF, 32'h80000000, 32'd0);
        chk("swap_flags", {29'd0, equal, less_than, less_than_unsigned}, 32'h1);
        step_r("sltu_swap", 4'd9, 32'h7FFFFFFF, 32'h80000000, 32'd1);

        step_r("b2b_add", 4'd0, 32'd3, 32'd1, 32'd4);
        step_r("b2b_sub", 4'd1, 32'd3, 32'd1, 32'd2);
        step_r("b2b_undef", 4'd15, 32'd3, 32'd1, 32'd0);

        // Sweep every opcode over a few operand pairs; the compare process checks each cycle.
        for (int op = 0; op < 16; op++) begin
            step(4'(op), 32'h12345678, 32'h87654321);
            step(4'(op), 32'hFFFFFFFF, 32'hFFFFFFFF);
            step(4'(op), $urandom, $urandom);
        end

        @(negedge clk);
        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
